// File: rtl/window_scan_counter.sv
// ============================================================================
// Module      : window_scan_counter
// Description : Raster-order scan generator for a KxK kernel sliding over an
//               (X_END+1) x (Y_END+1) image.  For each centre pixel it steps
//               through every kernel tap.  It also produces the neighbour
//               coordinate, the linear neighbour address, a bounds flag and a
//               last-tap flag.
//               Optional macro WINDOW_CLAMP_EN: when it is defined, neighbour
//               coordinates are clamped to the image (border replicate) and
//               in_bounds_o is tied high.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_scan_counter #(
  parameter int X_END = 3,
  parameter int Y_END = 3,
  parameter int K     = 3,
  parameter int XW    = $clog2(X_END + 1),
  parameter int YW    = $clog2(Y_END + 1),
  parameter int KW    = (K > 1) ? $clog2(K) : 1,
  parameter int AW    = $clog2((X_END + 1) * (Y_END + 1))
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          inc_i,
  input  logic          clear_i,
  output logic [XW-1:0] X_o,
  output logic [YW-1:0] Y_o,
  output logic [KW-1:0] KX_o,
  output logic [KW-1:0] KY_o,
  output logic [XW-1:0] NX_o,
  output logic [YW-1:0] NY_o,
  output logic [AW-1:0] addr_o,
  output logic          in_bounds_o,
  output logic          tap_last_o,
  output logic          busy_o,
  output logic          finished_o
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int            HALF    = (K - 1) / 2;
  localparam logic [XW-1:0] X_LAST  = XW'(X_END);
  localparam logic [YW-1:0] Y_LAST  = YW'(Y_END);
  localparam logic [KW-1:0] K_LAST  = KW'(K - 1);
  localparam logic [AW-1:0] ROW_LEN = AW'(X_END + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and counters
  // --------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [XW-1:0] x_q,  x_d;
  logic [YW-1:0] y_q,  y_d;
  logic [KW-1:0] kx_q, kx_d;
  logic [KW-1:0] ky_q, ky_d;

  logic w_tap_last;
  logic w_pix_last;

  // The final tap of a pixel, and the final pixel of the image.
  assign w_tap_last = (kx_q == K_LAST) && (ky_q == K_LAST);
  assign w_pix_last = (x_q == X_LAST) && (y_q == Y_LAST);

  // State register and counters; an asynchronous reset returns to IDLE with all counters zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
    end
  end

  // Next-state logic with priority clear > start > inc; the counters advance like an odometer, KX being the fastest digit.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    kx_d    = kx_q;
    ky_d    = ky_q;

    if (clear_i) begin
      state_d = S_IDLE;
      x_d     = '0;
      y_d     = '0;
      kx_d    = '0;
      ky_d    = '0;
    end else if (start_i && (state_q != S_SCAN)) begin
      state_d = S_SCAN;
      x_d     = '0;
      y_d     = '0;
      kx_d    = '0;
      ky_d    = '0;
    end else if (inc_i && (state_q == S_SCAN)) begin
      if (w_tap_last && w_pix_last) begin
        // Final tap of the image: counters keep their final values.
        state_d = S_DONE;
      end else if (kx_q != K_LAST) begin
        kx_d = kx_q + KW'(1);
      end else begin
        kx_d = '0;
        if (ky_q != K_LAST) begin
          ky_d = ky_q + KW'(1);
        end else begin
          ky_d = '0;
          if (x_q != X_LAST) begin
            x_d = x_q + XW'(1);
          end else begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Neighbour coordinate (combinational from the registers)
  // --------------------------------------------------------------------------
  // Two extra bits leave room for a sign and for centre + kernel offset overflow.
  logic signed [XW+1:0] w_raw_x;
  logic signed [YW+1:0] w_raw_y;
  logic                 w_x_neg, w_x_over;
  logic                 w_y_neg, w_y_over;

  assign w_raw_x  = (XW + 2)'(int'(x_q) + int'(kx_q) - HALF);
  assign w_raw_y  = (YW + 2)'(int'(y_q) + int'(ky_q) - HALF);

  assign w_x_neg  = w_raw_x[XW+1];
  assign w_y_neg  = w_raw_y[YW+1];
  assign w_x_over = (int'(w_raw_x) > X_END);
  assign w_y_over = (int'(w_raw_y) > Y_END);

`ifdef WINDOW_CLAMP_EN
  // Border replicate: out-of-range coordinates are held at the nearest edge.
  always_comb begin
    NX_o = w_raw_x[XW-1:0];
    NY_o = w_raw_y[YW-1:0];
    if (w_x_neg) begin
      NX_o = '0;
    end else if (w_x_over) begin
      NX_o = X_LAST;
    end
    if (w_y_neg) begin
      NY_o = '0;
    end else if (w_y_over) begin
      NY_o = Y_LAST;
    end
  end

  assign in_bounds_o = 1'b1;
`else
  // Raw low bits are passed through; the bounds flag tells the consumer to ignore them.
  always_comb begin
    NX_o = w_raw_x[XW-1:0];
    NY_o = w_raw_y[YW-1:0];
  end

  assign in_bounds_o = !(w_x_neg || w_x_over || w_y_neg || w_y_over);
`endif

  // Linear address of the neighbour inside a row-major image buffer.
  assign addr_o = (AW'(NY_o) * ROW_LEN) + AW'(NX_o);

  // --------------------------------------------------------------------------
  // Remaining outputs
  // --------------------------------------------------------------------------
  assign X_o        = x_q;
  assign Y_o        = y_q;
  assign KX_o       = kx_q;
  assign KY_o       = ky_q;
  assign tap_last_o = w_tap_last;
  assign busy_o     = (state_q == S_SCAN);
  assign finished_o = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_window_scan_counter.sv
// ============================================================================
// Module      : tb_window_scan_counter
// Description : Self-checking bench for window_scan_counter (X_END=Y_END=K=3).
//               It applies table vectors, model-driven sequences and a
//               scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_scan_counter;

  localparam int XE    = 3;
  localparam int YE    = 3;
  localparam int KK    = 3;
  localparam int TOTAL = (XE + 1) * (YE + 1) * KK * KK;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       inc_i = 1'b0;
  logic       clear_i = 1'b0;
  logic [1:0] X_o, Y_o, KX_o, KY_o, NX_o, NY_o;
  logic [3:0] addr_o;
  logic       in_bounds_o, tap_last_o, busy_o, finished_o;

  window_scan_counter #(.X_END(XE), .Y_END(YE), .K(KK)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .inc_i(inc_i),
    .clear_i(clear_i), .X_o(X_o), .Y_o(Y_o), .KX_o(KX_o), .KY_o(KY_o),
    .NX_o(NX_o), .NY_o(NY_o), .addr_o(addr_o), .in_bounds_o(in_bounds_o),
    .tap_last_o(tap_last_o), .busy_o(busy_o), .finished_o(finished_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int x, y, kx, ky;
    bit busy, fin;
  } exp_t;

  typedef struct {
    bit c, s, n;
    int x, y, kx, ky;
    bit busy, fin;
  } vec_t;

  exp_t q_exp[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: state 0=idle, 1=scan, 2=done.
  int m_st = 0, mx = 0, my = 0, mkx = 0, mky = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  // Pop one expectation and compare every output against it.
  task automatic pop_check(input string tag);
    exp_t e;
    int nxr, nyr, nx, ny, inb;
    if (q_exp.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e   = q_exp.pop_front();
    nxr = e.x + e.kx - (KK - 1) / 2;
    nyr = e.y + e.ky - (KK - 1) / 2;
`ifdef WINDOW_CLAMP_EN
    nx  = (nxr < 0) ? 0 : (nxr > XE) ? XE : nxr;
    ny  = (nyr < 0) ? 0 : (nyr > YE) ? YE : nyr;
    inb = 1;
`else
    nx  = nxr & 3;
    ny  = nyr & 3;
    inb = (nxr >= 0 && nxr <= XE && nyr >= 0 && nyr <= YE) ? 1 : 0;
`endif
    chk({tag, ".X"},    32'(X_o),  e.x);
    chk({tag, ".Y"},    32'(Y_o),  e.y);
    chk({tag, ".KX"},   32'(KX_o), e.kx);
    chk({tag, ".KY"},   32'(KY_o), e.ky);
    chk({tag, ".NX"},   32'(NX_o), nx);
    chk({tag, ".NY"},   32'(NY_o), ny);
    chk({tag, ".addr"}, 32'(addr_o), (ny * (XE + 1) + nx) % 16);
    chk({tag, ".inb"},  32'(in_bounds_o), inb);
    chk({tag, ".last"}, 32'(tap_last_o), (e.kx == KK - 1 && e.ky == KK - 1) ? 1 : 0);
    chk({tag, ".busy"}, 32'(busy_o), 32'(e.busy));
    chk({tag, ".fin"},  32'(finished_o), 32'(e.fin));
  endtask

  // Model update using a linear tap index, decomposed back into coordinates.
  task automatic model_apply(input bit c, input bit s, input bit n);
    int t, pix;
    if (c) begin
      m_st = 0; mx = 0; my = 0; mkx = 0; mky = 0;
    end else if (s && m_st != 1) begin
      m_st = 1; mx = 0; my = 0; mkx = 0; mky = 0;
    end else if (n && m_st == 1) begin
      t = ((my * (XE + 1) + mx) * KK * KK) + mky * KK + mkx + 1;
      if (t == TOTAL) begin
        m_st = 2;
      end else begin
        mkx = t % KK;
        mky = (t / KK) % KK;
        pix = t / (KK * KK);
        mx  = pix % (XE + 1);
        my  = pix / (XE + 1);
      end
    end
  endtask

  function automatic exp_t model_exp();
    exp_t e;
    e.x = mx; e.y = my; e.kx = mkx; e.ky = mky;
    e.busy = (m_st == 1);
    e.fin  = (m_st == 2);
    return e;
  endfunction

  // Drive inputs just after a falling edge and update the model.
  task automatic drive(input bit c, input bit s, input bit n);
    clear_i = c; start_i = s; inc_i = n;
    model_apply(c, s, n);
  endtask

  // Clock one rising edge, then sample on the following falling edge.
  task automatic tick(input string tag);
    @(posedge clk_i);
    @(negedge clk_i);
    clear_i = 1'b0; start_i = 1'b0; inc_i = 1'b0;
    pop_check(tag);
  endtask

  task automatic step_model(input bit c, input bit s, input bit n, input string tag);
    drive(c, s, n);
    q_exp.push_back(model_exp());
    tick(tag);
  endtask

  task automatic step_fixed(input bit c, input bit s, input bit n, input exp_t e, input string tag);
    drive(c, s, n);
    q_exp.push_back(e);
    tick(tag);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[14];
    exp_t e;

    tbl[0]  = '{0, 1, 0, 0, 0, 0, 0, 1, 0};  // start
    tbl[1]  = '{0, 0, 1, 0, 0, 1, 0, 1, 0};
    tbl[2]  = '{0, 0, 1, 0, 0, 2, 0, 1, 0};
    tbl[3]  = '{0, 0, 1, 0, 0, 0, 1, 1, 0};  // KX wraps, KY increments
    tbl[4]  = '{0, 1, 1, 0, 0, 1, 1, 1, 0};  // start ignored in SCAN
    tbl[5]  = '{0, 0, 0, 0, 0, 1, 1, 1, 0};  // idle cycle holds
    tbl[6]  = '{0, 0, 1, 0, 0, 2, 1, 1, 0};
    tbl[7]  = '{0, 0, 1, 0, 0, 0, 2, 1, 0};
    tbl[8]  = '{0, 0, 1, 0, 0, 1, 2, 1, 0};
    tbl[9]  = '{0, 0, 1, 0, 0, 2, 2, 1, 0};  // 8th inc: last tap
    tbl[10] = '{0, 0, 1, 1, 0, 0, 0, 1, 0};  // 9th inc: next pixel
    tbl[11] = '{1, 0, 1, 0, 0, 0, 0, 0, 0};  // clear beats inc
    tbl[12] = '{0, 0, 1, 0, 0, 0, 0, 0, 0};  // inc in IDLE ignored
    tbl[13] = '{0, 1, 0, 0, 0, 0, 0, 1, 0};  // restart

    // Reset state
    repeat (2) @(negedge clk_i);
    q_exp.push_back('{0, 0, 0, 0, 0, 0});
    pop_check("reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    q_exp.push_back('{0, 0, 0, 0, 0, 0});
    pop_check("post_reset_idle");

    // Table-driven vectors
    for (int i = 0; i < 14; i++) begin
      e = '{tbl[i].x, tbl[i].y, tbl[i].kx, tbl[i].ky, tbl[i].busy, tbl[i].fin};
      step_fixed(tbl[i].c, tbl[i].s, tbl[i].n, e, $sformatf("vec%0d", i));
    end

    // Full scan: the final inc enters DONE with the counters held
    step_model(1, 0, 0, "scan_clear");
    step_model(0, 1, 0, "scan_start");
    for (int i = 0; i < TOTAL - 1; i++) begin
      step_model(0, 0, 1, $sformatf("scan%0d", i));
    end
    step_fixed(0, 0, 1, '{3, 3, 2, 2, 0, 1}, "scan_done");
    step_fixed(0, 0, 1, '{3, 3, 2, 2, 0, 1}, "done_inc_hold");
    step_fixed(0, 1, 0, '{0, 0, 0, 0, 1, 0}, "done_restart");

    // Clear together with inc after 20 incs
    for (int i = 0; i < 20; i++) begin
      step_model(0, 0, 1, $sformatf("pre_clear%0d", i));
    end
    step_fixed(1, 0, 1, '{0, 0, 0, 0, 0, 0}, "clear_inc");

    // Asynchronous reset in the middle of a scan
    step_model(0, 1, 0, "rst_seq_start");
    for (int i = 0; i < 13; i++) begin
      step_model(0, 0, 1, $sformatf("pre_rst%0d", i));
    end
    #2;
    rst_i = 1'b1;
    model_apply(1, 0, 0);
    #1;
    q_exp.push_back('{0, 0, 0, 0, 0, 0});
    pop_check("async_rst");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    step_fixed(0, 1, 0, '{0, 0, 0, 0, 1, 0}, "rst_restart");
    step_fixed(0, 0, 1, '{0, 0, 1, 0, 1, 0}, "rst_restart_inc");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/window_scan_counter.md
WINDOW_SCAN_COUNTER -- requirements
Module: window_scan_counter

Interface
REQ-001 Parameter X_END, default 3: last pixel column index; shall be at least 1.
REQ-002 Parameter Y_END, default 3: last pixel row index; shall be at least 1.
REQ-003 Parameter K, default 3: kernel edge length; shall be odd and at least 1.
REQ-004 Parameter XW, default $clog2(X_END+1): column width; parameter YW, default $clog2(Y_END+1): row width.
REQ-005 Parameter KW, default $clog2(K) (minimum 1): kernel-index width; parameter AW, default $clog2((X_END+1)*(Y_END+1)): address width.
REQ-006 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_i  input  1  asynchronous, active-high reset.
REQ-008 start_i  input  1  begin a scan from IDLE or DONE.
REQ-009 inc_i  input  1  advance one kernel tap; acted on only in SCAN.
REQ-010 clear_i  input  1  synchronous abort to IDLE.
REQ-011 X_o/Y_o  output  XW/YW  current centre-pixel column/row.
REQ-012 KX_o/KY_o  output  KW  current kernel tap column/row, 0..K-1.
REQ-013 NX_o/NY_o  output  XW/YW  neighbour coordinate.
REQ-014 addr_o  output  AW  NY_o*(X_END+1)+NX_o.
REQ-015 in_bounds_o  output  1  neighbour lies inside the image.
REQ-016 tap_last_o  output  1  current tap is the final tap (KX=KY=K-1) of the pixel.
REQ-017 busy_o  output  1  high in SCAN; finished_o  output  1  high in DONE.

Function
REQ-018 FSM states IDLE, SCAN, DONE; busy_o and finished_o are decoded from the state register.
REQ-019 Control priority, highest first: clear_i, start_i, inc_i.
REQ-020 clear_i in any state: next state IDLE, all counters zero.
REQ-021 start_i in IDLE or DONE: next state SCAN, all counters zero; start_i is ignored in SCAN.
REQ-022 inc_i in SCAN advances in raster order: KX; on KX=K-1, KX wraps to 0 and KY increments; on KY=K-1 wrap, X increments; on X=X_END wrap, Y increments.
REQ-023 inc_i on tap KX=KY=K-1 at X=X_END, Y=Y_END: next state DONE; counters hold their final values.
REQ-024 inc_i in IDLE or DONE: no effect.
REQ-025 Raw neighbour coordinate: X+KX-(K-1)/2 and Y+KY-(K-1)/2, evaluated signed at XW+2 and YW+2 bits.
REQ-026 NX_o, NY_o, addr_o, in_bounds_o and tap_last_o are combinational from the registers, with zero latency after each counter update.
REQ-027 The full scan takes exactly (X_END+1)*(Y_END+1)*K*K accepted inc_i pulses.

Reset
REQ-028 rst_i asserted, including mid-scan: immediately state IDLE; X, Y, KX and KY zero; busy_o and finished_o low.
REQ-029 After reset release, the block waits in IDLE for start_i.

Configuration
REQ-030 Macro WINDOW_CLAMP_EN defined: out-of-range raw coordinates are clamped to [0,X_END] and [0,Y_END] (border replicate); in_bounds_o is tied high.
REQ-031 Macro WINDOW_CLAMP_EN undefined: NX_o and NY_o carry the low XW/YW bits of the raw coordinate; in_bounds_o is low whenever either raw coordinate is negative or greater than its END.

Verification (X_END=3, Y_END=3, K=3)
REQ-032 Stimulus: start, then check tap 0 -> X=Y=KX=KY=0. With the macro: NX=NY=0, addr=0, in_bounds=1. Without the macro: in_bounds=0.
REQ-033 Stimulus: start, then 8 inc -> tap_last_o=1. On the 9th inc -> X=1, Y=0, KX=KY=0, tap_last_o=0.
REQ-034 Stimulus: start, then 144 inc -> finished_o=1 and busy_o=0 on the next cycle; a further inc leaves all outputs unchanged.
REQ-035 Stimulus: after 20 inc, assert clear_i and inc_i in the same cycle -> IDLE, all counters 0, busy_o=0.
REQ-036 Stimulus: rst_i pulse mid-scan, asynchronous to the clock edge -> outputs zero immediately; a subsequent start restarts the scan at tap 0.
REQ-037 Stimulus: start_i in DONE -> SCAN, finished_o=0, counters zero.
